// File: rtl/flow_stat_mem.sv
// Per-flow byte/packet statistics table with a queued update path and a read/clear port.
// Updates and reads share one table port; an IDLE-state round-robin arbiter serialises them.
module flow_stat_mem #(
  parameter int A_WIDTH   = 10,
  parameter int D_WIDTH   = 32,
  parameter int PKT_WIDTH = 15,
  parameter int CNT_WIDTH = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [A_WIDTH-1:0]   rx_flow_num_i,
  input  logic [PKT_WIDTH-1:0] pkt_size_i,
  input  logic                 rd_valid_i,
  output logic                 rd_ready_o,
  input  logic [A_WIDTH-1:0]   rd_flow_num_i,
  input  logic                 rd_clear_i,
  output logic                 rd_valid_o,
  output logic [D_WIDTH-1:0]   rd_bytes_o,
  output logic [CNT_WIDTH-1:0] rd_pkts_o,
  output logic                 init_busy_o,
  output logic [FIFO_AW:0]     fifo_count_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned FLOWS = 1 << A_WIDTH;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_UPD_RD = 3'd2;
  localparam logic [2:0] ST_UPD_WR = 3'd3;
  localparam logic [2:0] ST_RD_RD  = 3'd4;
  localparam logic [2:0] ST_RD_OUT = 3'd5;

  localparam logic [FIFO_AW:0]   PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] ADR_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]           state_q;
  logic [A_WIDTH-1:0]   init_cnt_q;
  logic                 rd_pri_q;

  logic [A_WIDTH-1:0]   fifo_flow [DEPTH];
  logic [PKT_WIDTH-1:0] fifo_size [DEPTH];
  logic [FIFO_AW:0]     wr_ptr_q;
  logic [FIFO_AW:0]     rd_ptr_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;

  logic                 idle;
  logic                 grant_rd;
  logic                 grant_upd;

  logic [A_WIDTH-1:0]   upd_flow_q;
  logic [PKT_WIDTH-1:0] upd_size_q;
  logic [A_WIDTH-1:0]   rd_flow_q;
  logic                 rd_clr_q;

  logic [D_WIDTH-1:0]   tbl_bytes [FLOWS];
  logic [CNT_WIDTH-1:0] tbl_pkts  [FLOWS];
  logic [D_WIDTH-1:0]   tbl_bytes_q;
  logic [CNT_WIDTH-1:0] tbl_pkts_q;
  logic                 tbl_re;
  logic                 tbl_we;
  logic [A_WIDTH-1:0]   tbl_ra;
  logic [A_WIDTH-1:0]   tbl_wa;
  logic [D_WIDTH-1:0]   tbl_wbytes;
  logic [CNT_WIDTH-1:0] tbl_wpkts;

  logic [D_WIDTH:0]     bytes_sum;
  logic [D_WIDTH-1:0]   sat_bytes;
  logic [CNT_WIDTH-1:0] sat_pkts;

  logic [D_WIDTH-1:0]   hold_bytes_q;
  logic [CNT_WIDTH-1:0] hold_pkts_q;

  assign fifo_count_o = wr_ptr_q - rd_ptr_q;
  assign fifo_full    = fifo_count_o[FIFO_AW];
  assign fifo_empty   = (fifo_count_o == '0);
  assign init_busy_o  = (state_q == ST_INIT);
  assign wr_ready_o   = !fifo_full && !init_busy_o;
  assign push         = wr_valid_i && wr_ready_o;

  // Read wins when it holds priority or no update is queued; priority flips after every grant.
  assign idle       = (state_q == ST_IDLE);
  assign grant_rd   = idle && rd_valid_i && (fifo_empty || rd_pri_q);
  assign grant_upd  = idle && !fifo_empty && !grant_rd;
  assign rd_ready_o = grant_rd;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_flow[wr_ptr_q[FIFO_AW-1:0]] <= rx_flow_num_i;
      fifo_size[wr_ptr_q[FIFO_AW-1:0]] <= pkt_size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)      wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (grant_upd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant_upd) begin
      upd_flow_q <= fifo_flow[rd_ptr_q[FIFO_AW-1:0]];
      upd_size_q <= fifo_size[rd_ptr_q[FIFO_AW-1:0]];
    end
    if (grant_rd) begin
      rd_flow_q <= rd_flow_num_i;
      rd_clr_q  <= rd_clear_i;
    end
  end

  assign bytes_sum = {1'b0, tbl_bytes_q} + {{(D_WIDTH+1-PKT_WIDTH){1'b0}}, upd_size_q};
  assign sat_bytes = bytes_sum[D_WIDTH] ? '1 : bytes_sum[D_WIDTH-1:0];
  assign sat_pkts  = (&tbl_pkts_q) ? tbl_pkts_q : tbl_pkts_q + CNT_ONE;

  always_comb begin
    tbl_re     = 1'b0;
    tbl_ra     = upd_flow_q;
    tbl_we     = 1'b0;
    tbl_wa     = init_cnt_q;
    tbl_wbytes = '0;
    tbl_wpkts  = '0;
    case (state_q)
      ST_INIT:   tbl_we = 1'b1;
      ST_UPD_RD: tbl_re = 1'b1;
      ST_UPD_WR: begin
        tbl_we     = 1'b1;
        tbl_wa     = upd_flow_q;
        tbl_wbytes = sat_bytes;
        tbl_wpkts  = sat_pkts;
      end
      ST_RD_RD: begin
        tbl_re = 1'b1;
        tbl_ra = rd_flow_q;
      end
      ST_RD_OUT: begin
        tbl_we = rd_clr_q;
        tbl_wa = rd_flow_q;
      end
      default: ;
    endcase
  end

  // Write gated by reset so an in-flight update or clear is dropped.
  always_ff @(posedge clk_i) begin
    if (tbl_we && !rst_i) begin
      tbl_bytes[tbl_wa] <= tbl_wbytes;
      tbl_pkts[tbl_wa]  <= tbl_wpkts;
    end
    if (tbl_re) begin
      tbl_bytes_q <= tbl_bytes[tbl_ra];
      tbl_pkts_q  <= tbl_pkts[tbl_ra];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      rd_pri_q     <= 1'b1;
      hold_bytes_q <= '0;
      hold_pkts_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + ADR_ONE;
          if (init_cnt_q == '1) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (grant_rd) begin
            state_q  <= ST_RD_RD;
            rd_pri_q <= 1'b0;
          end else if (grant_upd) begin
            state_q  <= ST_UPD_RD;
            rd_pri_q <= 1'b1;
          end
        end
        ST_UPD_RD: state_q <= ST_UPD_WR;
        ST_UPD_WR: state_q <= ST_IDLE;
        ST_RD_RD:  state_q <= ST_RD_OUT;
        ST_RD_OUT: begin
          state_q      <= ST_IDLE;
          hold_bytes_q <= tbl_bytes_q;
          hold_pkts_q  <= tbl_pkts_q;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Read data is presented straight from the table register while valid, then held.
  assign rd_valid_o = (state_q == ST_RD_OUT);
  assign rd_bytes_o = rd_valid_o ? tbl_bytes_q : hold_bytes_q;
  assign rd_pkts_o  = rd_valid_o ? tbl_pkts_q  : hold_pkts_q;

endmodule

// File: tb/tb_flow_stat_mem.sv
// Bench for flow_stat_mem: a wide-counter instance and a narrow saturating instance share stimulus,
// both checked every cycle against a transaction-level model (queue + per-flow totals).
module tb_flow_stat_mem;

  localparam int AW    = 4;
  localparam int FAW   = 3;
  localparam int NFLOW = 16;
  localparam int DEPTH = 8;
  localparam longint M_BMAX = 64'd4294967295;
  localparam longint M_PMAX = 64'd65535;
  localparam longint S_BMAX = 64'd255;
  localparam longint S_PMAX = 64'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_flow;
  logic [14:0]   pkt_size;
  logic          rd_valid;
  logic [AW-1:0] rd_flow;
  logic          rd_clear;

  logic          m_wr_ready, m_rd_ready, m_rd_valid, m_init_busy;
  logic [31:0]   m_rd_bytes;
  logic [15:0]   m_rd_pkts;
  logic [FAW:0]  m_fifo_count;
  logic          s_wr_ready, s_rd_ready, s_rd_valid, s_init_busy;
  logic [7:0]    s_rd_bytes;
  logic [1:0]    s_rd_pkts;
  logic [FAW:0]  s_fifo_count;

  flow_stat_mem #(.A_WIDTH(AW), .D_WIDTH(32), .PKT_WIDTH(15), .CNT_WIDTH(16), .FIFO_AW(FAW)) dut (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(m_wr_ready),
    .rx_flow_num_i(wr_flow), .pkt_size_i(pkt_size), .rd_valid_i(rd_valid), .rd_ready_o(m_rd_ready),
    .rd_flow_num_i(rd_flow), .rd_clear_i(rd_clear), .rd_valid_o(m_rd_valid), .rd_bytes_o(m_rd_bytes),
    .rd_pkts_o(m_rd_pkts), .init_busy_o(m_init_busy), .fifo_count_o(m_fifo_count)
  );

  flow_stat_mem #(.A_WIDTH(AW), .D_WIDTH(8), .PKT_WIDTH(8), .CNT_WIDTH(2), .FIFO_AW(FAW)) dut_sat (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(s_wr_ready),
    .rx_flow_num_i(wr_flow), .pkt_size_i(pkt_size[7:0]), .rd_valid_i(rd_valid), .rd_ready_o(s_rd_ready),
    .rd_flow_num_i(rd_flow), .rd_clear_i(rd_clear), .rd_valid_o(s_rd_valid), .rd_bytes_o(s_rd_bytes),
    .rd_pkts_o(s_rd_pkts), .init_busy_o(s_init_busy), .fifo_count_o(s_fifo_count)
  );

  // Reference model: totals per flow, queue of accepted updates, service occupancy.
  longint mb[NFLOW], mp[NFLOW], sb[NFLOW], sp[NFLOW];
  int     q_flow[$];
  int     q_size[$];
  int     busy, init_left, out_cd;
  bit     rd_pri, upd_active;
  longint pend_mb, pend_mp, pend_sb, pend_sp;
  longint cur_mb, cur_mp, cur_sb, cur_sp;

  int n_tests = 0;
  int n_fail  = 0;

  bit          t_push, t_grant_rd;
  logic        o_wr_ready, o_rd_valid, o_init_busy;
  logic [FAW:0] o_fifo_count;
  logic [31:0] o_mb;
  logic [15:0] o_mp;
  logic [7:0]  o_sb;
  logic [1:0]  o_sp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NFLOW; i++) begin
      mb[i] = 0; mp[i] = 0; sb[i] = 0; sp[i] = 0;
    end
    q_flow.delete();
    q_size.delete();
    busy = 0; out_cd = 0; init_left = NFLOW;
    rd_pri = 1'b1; upd_active = 1'b0;
    cur_mb = 0; cur_mp = 0; cur_sb = 0; cur_sp = 0;
  endtask

  task automatic apply_update(input int f, input int s);
    mb[f] = (mb[f] + s > M_BMAX) ? M_BMAX : mb[f] + s;
    mp[f] = (mp[f] + 1 > M_PMAX) ? M_PMAX : mp[f] + 1;
    sb[f] = (sb[f] + (s % 256) > S_BMAX) ? S_BMAX : sb[f] + (s % 256);
    sp[f] = (sp[f] + 1 > S_PMAX) ? S_PMAX : sp[f] + 1;
  endtask

  // One clock cycle: entered just after a falling edge with inputs already driven.
  task automatic tick();
    bit idle, exp_wr_ready, gr_rd, gr_up;
    int f;
    int s;
    #1;
    idle         = (init_left == 0) && (busy == 0);
    exp_wr_ready = (init_left == 0) && (q_flow.size() < DEPTH);
    gr_rd        = idle && rd_valid && ((q_flow.size() == 0) || rd_pri);
    gr_up        = idle && (q_flow.size() != 0) && !gr_rd;
    chk("wr_ready",   m_wr_ready,   exp_wr_ready);
    chk("rd_ready",   m_rd_ready,   gr_rd);
    chk("init_busy",  m_init_busy,  init_left != 0);
    chk("fifo_count", m_fifo_count, q_flow.size());
    chk("rd_valid",   m_rd_valid,   out_cd == 1);
    chk("rd_bytes",   m_rd_bytes,   cur_mb);
    chk("rd_pkts",    m_rd_pkts,    cur_mp);
    chk("sat_wr_ready", s_wr_ready, exp_wr_ready);
    chk("sat_rd_ready", s_rd_ready, gr_rd);
    chk("sat_rd_valid", s_rd_valid, out_cd == 1);
    chk("sat_rd_bytes", s_rd_bytes, cur_sb);
    chk("sat_rd_pkts",  s_rd_pkts,  cur_sp);
    o_wr_ready = m_wr_ready; o_rd_valid = m_rd_valid; o_init_busy = m_init_busy;
    o_fifo_count = m_fifo_count;
    o_mb = m_rd_bytes; o_mp = m_rd_pkts; o_sb = s_rd_bytes; o_sp = s_rd_pkts;
    t_push     = !rst && wr_valid && exp_wr_ready;
    t_grant_rd = !rst && gr_rd;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (init_left > 0) init_left--;
      if (busy > 0) busy--;
      if (out_cd > 0) out_cd--;
      if (out_cd == 1) begin
        cur_mb = pend_mb; cur_mp = pend_mp; cur_sb = pend_sb; cur_sp = pend_sp;
      end
      if (gr_rd) begin
        f = int'(rd_flow);
        pend_mb = mb[f]; pend_mp = mp[f]; pend_sb = sb[f]; pend_sp = sp[f];
        if (rd_clear) begin
          mb[f] = 0; mp[f] = 0; sb[f] = 0; sp[f] = 0;
        end
        busy = 2; out_cd = 2; rd_pri = 1'b0; upd_active = 1'b0;
      end
      if (gr_up) begin
        f = q_flow.pop_front();
        s = q_size.pop_front();
        apply_update(f, s);
        busy = 2; rd_pri = 1'b1; upd_active = 1'b1;
      end
      if (wr_valid && exp_wr_ready) begin
        q_flow.push_back(int'(wr_flow));
        q_size.push_back(int'(pkt_size));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push(input int f, input int s);
    wr_valid = 1'b1;
    wr_flow  = 4'(f);
    pkt_size = 15'(s);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (t_push) break;
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_flow(input int f, input bit clr, output longint b, output longint p,
                           output longint sbv, output longint spv);
    int lat;
    rd_valid = 1'b1;
    rd_flow  = 4'(f);
    rd_clear = clr;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (t_grant_rd) break;
    end
    rd_valid = 1'b0;
    rd_clear = 1'b0;
    lat = -1; b = -1; p = -1; sbv = -1; spv = -1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (o_rd_valid === 1'b1) begin
        lat = j; b = o_mb; p = o_mp; sbv = o_sb; spv = o_sp;
        break;
      end
    end
    chk("rd_latency", lat, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    longint b, p, sbv, spv;
    int n, acc, sum5;
    bit saw_full;

    rst = 1'b1; wr_valid = 1'b0; wr_flow = '0; pkt_size = '0;
    rd_valid = 1'b0; rd_flow = '0; rd_clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    tick();
    chk("rst_init_busy", o_init_busy, 1);
    chk("rst_fifo_count", o_fifo_count, 0);
    rst = 1'b0;

    // Initialisation length and all-zero table.
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_init_busy === 1'b1) n++;
      else break;
    end
    chk("init_cycles", n, 16);
    for (int f = 0; f < NFLOW; f++) begin
      read_flow(f, 1'b0, b, p, sbv, spv);
      chk("zero_bytes", b, 0);
      chk("zero_pkts", p, 0);
    end

    // Accumulation then read/clear/read on flow 3.
    push(3, 100); push(3, 200); push(3, 50);
    idle_cycles(12);
    read_flow(3, 1'b0, b, p, sbv, spv);
    chk("f3_bytes", b, 350);
    chk("f3_pkts", p, 3);
    read_flow(3, 1'b1, b, p, sbv, spv);
    chk("f3_clr_bytes", b, 350);
    chk("f3_clr_pkts", p, 3);
    read_flow(3, 1'b0, b, p, sbv, spv);
    chk("f3_after_bytes", b, 0);
    chk("f3_after_pkts", p, 0);

    // Saturation in the narrow instance.
    push(1, 200); push(1, 100); push(1, 1); push(1, 1); push(1, 1);
    idle_cycles(20);
    read_flow(1, 1'b0, b, p, sbv, spv);
    chk("f1_bytes", b, 303);
    chk("f1_pkts", p, 5);
    chk("sat_f1_bytes", sbv, 255);
    chk("sat_f1_pkts", spv, 3);

    // Continuous read requests while the update FIFO is driven to full.
    rd_valid = 1'b1; rd_flow = 4'd5; rd_clear = 1'b0;
    wr_valid = 1'b1; wr_flow = 4'd5;
    acc = 0; sum5 = 0; saw_full = 1'b0;
    for (int k = 0; k < 100 && acc < DEPTH + 2; k++) begin
      pkt_size = 15'($urandom_range(1, 1000));
      tick();
      if (t_push) begin
        acc++;
        sum5 += int'(pkt_size);
      end
      if (o_wr_ready === 1'b0 && o_fifo_count == DEPTH) saw_full = 1'b1;
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q_flow.size() == 0) break;
      tick();
    end
    rd_valid = 1'b0;
    idle_cycles(8);
    chk("full_seen", saw_full, 1);
    chk("offered_accepted", acc, DEPTH + 2);
    read_flow(5, 1'b0, b, p, sbv, spv);
    chk("f5_pkts", p, DEPTH + 2);
    chk("f5_bytes", b, sum5);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_flow  = 4'($urandom_range(0, NFLOW - 1));
      pkt_size = 15'($urandom_range(0, 32767));
      rd_valid = ($urandom_range(0, 99) < 30);
      rd_flow  = 4'($urandom_range(0, NFLOW - 1));
      rd_clear = ($urandom_range(0, 9) == 0);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rd_clear = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q_flow.size() == 0 && busy == 0 && out_cd == 0) break;
      tick();
    end
    for (int f = 0; f < NFLOW; f++) read_flow(f, 1'b0, b, p, sbv, spv);

    // Reset while an update is being written back with five more queued.
    wr_flow = 4'd9;
    pkt_size = 15'd77;
    for (int k = 0; k < 60; k++) begin
      if (upd_active && busy == 1 && q_flow.size() == 5) begin
        rst = 1'b1;
        wr_valid = 1'b0;
        tick();
        break;
      end
      wr_valid = (q_flow.size() < 5);
      tick();
    end
    chk("queued_at_rst", o_fifo_count, 5);
    rst = 1'b0;
    wr_valid = 1'b0;
    tick();
    chk("fifo_after_rst", o_fifo_count, 0);
    chk("init_restart", o_init_busy, 1);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_init_busy === 1'b1) n++;
      else break;
    end
    chk("init_cycles_again", n, 16);
    read_flow(9, 1'b0, b, p, sbv, spv);
    chk("f9_bytes", b, 0);
    chk("f9_pkts", p, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_stat_mem.md
FLOW_STAT_MEM -- requirements
Module: flow_stat_mem

Interface
REQ-001 Parameter A_WIDTH, 10: flow index width; table holds 2^A_WIDTH flows.
REQ-002 Parameter D_WIDTH, 32: per-flow byte counter width.
REQ-003 Parameter PKT_WIDTH, 15: packet size width; PKT_WIDTH <= D_WIDTH.
REQ-004 Parameter CNT_WIDTH, 16: per-flow packet counter width.
REQ-005 Parameter FIFO_AW, 4: update FIFO depth is 2^FIFO_AW.
REQ-006 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  single clock; all logic on its rising edge.
REQ-008 rst_i  in  1  synchronous, active-high reset.
REQ-009 wr_valid_i  in  1  packet-update request.
REQ-010 wr_ready_o  out  1  update accepted when wr_valid_i && wr_ready_o.
REQ-011 rx_flow_num_i  in  A_WIDTH  flow index of the update.
REQ-012 pkt_size_i  in  PKT_WIDTH  packet size in bytes.
REQ-013 rd_valid_i  in  1  statistics read request.
REQ-014 rd_ready_o  out  1  read accepted when rd_valid_i && rd_ready_o.
REQ-015 rd_flow_num_i  in  A_WIDTH  flow index to read.
REQ-016 rd_clear_i  in  1  sampled with the read; clear the entry after reading.
REQ-017 rd_valid_o  out  1  one-cycle strobe qualifying rd_bytes_o and rd_pkts_o.
REQ-018 rd_bytes_o  out  D_WIDTH  byte count of the read flow.
REQ-019 rd_pkts_o  out  CNT_WIDTH  packet count of the read flow.
REQ-020 init_busy_o  out  1  table initialisation in progress.
REQ-021 fifo_count_o  out  FIFO_AW+1  number of queued updates.

Function
REQ-022 States: INIT, IDLE, UPD_RD, UPD_WR, RD_RD, RD_OUT.
REQ-023 INIT: address counter runs 0..2^A_WIDTH-1, writing {0,0} to one entry per cycle; after the last entry -> IDLE; init_busy_o=1 only in INIT.
REQ-024 Update FIFO: wr_ready_o = !fifo_full && !init_busy_o; a push and a pop in the same cycle leave fifo_count_o unchanged; a push when full is impossible (ready low).
REQ-025 rd_ready_o = 1 only in IDLE, and only when the arbiter grants the read (REQ-026).
REQ-026 IDLE arbitration: a read alone or an update alone (FIFO non-empty) is served; with both pending, round-robin alternates, starting with read priority after reset.
REQ-027 Update path: grant at T pops the FIFO head; UPD_RD at T+1 issues a synchronous table read; UPD_WR at T+2 writes bytes+pkt_size and pkts+1; IDLE at T+3.
REQ-028 Arithmetic: pkt_size zero-extended to D_WIDTH; both counters saturate at all-ones, never wrap.
REQ-029 Read path: accept at T captures the flow and clear flag; RD_RD at T+1; RD_OUT at T+2 with rd_valid_o=1 and data valid; IDLE at T+3.
REQ-030 rd_clear_i=1: {0,0} is written to the entry in the RD_OUT cycle; the returned data is the pre-clear value.
REQ-031 rd_bytes_o and rd_pkts_o hold their last values when rd_valid_o=0.
REQ-032 An update popped before a read is granted is included in that read's result; no update is ever lost or double-counted.
REQ-033 Updates may be accepted during INIT only if they are not ready-gated; since they are gated, none are accepted.

Reset
REQ-034 rst_i=1 at a clock edge: state->INIT, FIFO emptied (fifo_count_o=0), init counter=0, arbiter->read priority, rd_valid_o=0, rd_bytes_o=0, rd_pkts_o=0, wr_ready_o=0, rd_ready_o=0, init_busy_o=1.
REQ-035 Reset mid-operation aborts any update or read in flight without a write-back; queued updates are discarded and INIT restarts.

Verification
REQ-036 Reset, A_WIDTH=4 -> init_busy_o high exactly 16 cycles; every flow then reads {0,0}.
REQ-037 Updates flow 3 sizes 100, 200, 50, then read flow 3 -> rd_bytes_o=350, rd_pkts_o=3, rd_valid_o two cycles after accept.
REQ-038 Read flow 3 with clear, then read again -> first returns 350/3, second returns 0/0.
REQ-039 CNT_WIDTH=2: 5 updates to flow 1 -> rd_pkts_o=3 (saturated); D_WIDTH=8 with sizes 200+100 -> rd_bytes_o=255.
REQ-040 Hold rd_valid_i=1 while 2^FIFO_AW+2 updates are offered -> wr_ready_o drops at full, grants alternate read/update, and all accepted updates are counted.
REQ-041 Assert rst_i during UPD_WR with 5 queued updates -> fifo_count_o=0 next cycle, INIT restarts, and the target flow reads 0 afterwards.
